fxp_div_q16: RTL and testbench

Sequential signed Q16.16 divider, the inverse companion of the package's Q16.16 multiply.
- Computes q = (a << FRAC) / b using a restoring, one-bit-per-cycle radix-2 algorithm on magnitudes.
- Sign is applied afterwards, then the result is saturated to 32 bits.
- Used by the signal/risk pipeline for ratio terms (e.g. exposure / LIMIT normalisation).
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/fxp_div_q16_pkg.sv | 9 +
 rtl/fxp_div_q16_if.sv | 24 ++
 rtl/fxp_div_q16.sv | 106 ++++++++++
 tb/tb_fxp_div_q16.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fxp_div_q16_pkg.sv
// fxp_div_q16_pkg: shared Q16.16 fixed-point constants and divider state type
package fxp_div_q16_pkg;
    localparam int FXP_WIDTH = 32;
    localparam int FXP_FRAC  = 16;
    localparam logic [31:0] FXP_MAX = 32'sh7FFFFFFF;
    localparam logic [31:0] FXP_MIN = 32'sh80000000;
    localparam int DIV_ITERS = FXP_WIDTH + FXP_FRAC;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/fxp_div_q16_if.sv
// fxp_div_q16_if: operand/result valid-ready bus of the Q16.16 divider
interface fxp_div_q16_if
    import fxp_div_q16_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic             out_ovf;
    logic             out_dz;
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_q, out_ovf, out_dz
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_q, out_ovf, out_dz
    );
endinterface

// File: rtl/fxp_div_q16.sv
// fxp_div_q16: sequential signed Q16.16 restoring divider; FXP_DIV_ROUND_EN adds a guard bit for round-half-away
module fxp_div_q16
    import fxp_div_q16_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int FRAC  = FXP_FRAC
)(
    input logic           clk,
    input logic           rst_n,
    fxp_div_q16_if.slave  bus
);
`ifdef FXP_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int N  = WIDTH + FRAC + RND;
    localparam int CW = $clog2(N);

    div_state_t       state, state_nx;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic [WIDTH-1:0] bm, rem, rem_nx, am_in, bm_in, q_fin, q_r;
    logic [N-1:0]     dvd, quo_nx, mq, lim;
    logic [N-2:0]     quo;
    logic [WIDTH:0]   rem_sh;
    logic             ge, last, ovf, ovf_r, dz_r, b_zero;

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_q     = q_r;
    assign bus.out_ovf   = ovf_r;
    assign bus.out_dz    = dz_r;

    assign am_in  = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
    assign bm_in  = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;
    assign b_zero = bus.in_b == '0;
    assign last   = cnt == CW'(N - 1);

    // One restoring step plus the final sign/saturation stage, used on the last iteration
    always_comb begin
        rem_sh = {rem, dvd[N-1]};
        ge     = rem_sh >= {1'b0, bm};
        rem_nx = ge ? WIDTH'(rem_sh - {1'b0, bm}) : rem_sh[WIDTH-1:0];
        quo_nx = {quo, ge};
`ifdef FXP_DIV_ROUND_EN
        mq     = (quo_nx >> 1) + N'(quo_nx[0]);
`else
        mq     = quo_nx;
`endif
        lim    = N'(FXP_MAX) + N'(sign);
        ovf    = mq > lim;
        q_fin  = ovf ? (sign ? FXP_MIN : FXP_MAX) : (sign ? -mq[WIDTH-1:0] : mq[WIDTH-1:0]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; divide by zero skips CALC entirely
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = b_zero ? DONE : CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sign  <= 1'b0;
            bm    <= '0;
            rem   <= '0;
            dvd   <= '0;
            quo   <= '0;
            q_r   <= '0;
            ovf_r <= 1'b0;
            dz_r  <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            sign  <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
            bm    <= bm_in;
            dvd   <= N'(am_in) << (FRAC + RND);
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            dz_r  <= b_zero;
            if (b_zero) q_r <= bus.in_a[WIDTH-1] ? FXP_MIN : FXP_MAX;
        end else if (state == CALC) begin
            rem <= rem_nx;
            dvd <= dvd << 1;
            quo <= quo_nx[N-2:0];
            cnt <= cnt + 1'b1;
            if (last) begin
                q_r   <= q_fin;
                ovf_r <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_fxp_div_q16.sv
// tb_fxp_div_q16: directed vectors for the Q16.16 divider, including backpressure and mid-operation reset
module tb_fxp_div_q16;
    import fxp_div_q16_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fxp_div_q16_if bus();
    fxp_div_q16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef FXP_DIV_ROUND_EN
    localparam int          LAT  = 49;
    localparam logic [31:0] Q2_0 = 32'd174763;
`else
    localparam int          LAT  = 48;
    localparam logic [31:0] Q2_0 = 32'd174762;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic eovf, input logic edz, input int elat);
        int lat;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        send(a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, bus.out_q, eq);
        check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eovf));
        check({tag, "_dz"}, 32'(bus.out_dz), 32'(edz));
        take();
        check({tag, "_taken"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        #12;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", bus.out_q, 32'd0);
        check("rst_ovf", 32'(bus.out_ovf), 32'd0);
        check("rst_dz", 32'(bus.out_dz), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("two_by_0p75", 32'd131072, 32'd49152, Q2_0, 1'b0, 1'b0, LAT);
        run("neg_quarter", -32'sd65536, 32'd262144, 32'hFFFFC000, 1'b0, 1'b0, LAT);
        run("neg_by_neg", -32'sd65536, -32'sd131072, 32'h00008000, 1'b0, 1'b0, LAT);
        run("neg_third", 32'd65536, -32'sd196608, 32'hFFFFAAAB, 1'b0, 1'b0, LAT);
        run("dz_pos", 32'd65536, 32'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 0);
        run("dz_neg", 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b1, 0);
        run("dz_zero", 32'd0, 32'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 0);
        run("ovf_max", 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, LAT);
        run("min_by_one", 32'h80000000, 32'd65536, 32'h80000000, 1'b0, 1'b0, LAT);
        run("min_by_neg1", 32'h80000000, -32'sd65536, 32'h7FFFFFFF, 1'b1, 1'b0, LAT);

        send(32'd131072, 32'd49152);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_q", bus.out_q, Q2_0);
            check("bp_flags", {30'd0, bus.out_ovf, bus.out_dz}, 32'd0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        check("bp_take_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_after_valid", 32'(bus.out_valid), 32'd0);
        check("bp_after_in_ready", 32'(bus.in_ready), 32'd1);

        run("dz_before_rst", 32'd65536, 32'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 0);
        send(32'd131072, 32'd49152);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_q", bus.out_q, 32'd0);
        check("mid_rst_flags", {30'd0, bus.out_ovf, bus.out_dz}, 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("after_rst", 32'd131072, 32'd49152, Q2_0, 1'b0, 1'b0, LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
